// File: rtl/shared_clause_ring.sv
// Shared broadcast ring: round-robin arbitrated writers feed a circular store whose
// head is presented through a registered broadcast port to every (other) core.
module shared_clause_ring #(
    parameter int NUM_CORES = 4,
    parameter int DEPTH     = 4096,
    parameter int DATA_W    = 64,
    parameter int OVERWRITE = 0,
    parameter int SKIP_SELF = 1,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int SRC_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_CORES-1:0]             write_req,
    input  logic [NUM_CORES-1:0][DATA_W-1:0] write_data,
    output logic [NUM_CORES-1:0]             write_grant,
    input  logic                             clear,
    output logic                             bcast_valid,
    output logic [DATA_W-1:0]                bcast_data,
    output logic [SRC_W-1:0]                 bcast_src,
    output logic [NUM_CORES-1:0]             bcast_dest,
    input  logic [NUM_CORES-1:0]             bcast_ready,
    output logic [PTR_W:0]                   occupancy,
    output logic                             full,
    output logic                             empty,
    output logic [15:0]                      drop_count
);

    localparam int ENTRY_W = DATA_W + SRC_W;
    localparam logic [PTR_W:0] FULL_LEVEL = (PTR_W+1)'(DEPTH);

    logic [ENTRY_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]     write_ptr;
    logic [PTR_W-1:0]     read_ptr;
    logic [SRC_W-1:0]     rr_ptr;
    logic [SRC_W-1:0]     grant_idx;
    logic                 grant_found;
    logic                 grant_any;
    logic                 allow_write;
    logic                 transfer;
    logic                 load;
    logic                 discard;
    logic                 drop_event;
    logic                 store_inc;
    logic [DATA_W-1:0]    head_data;
    logic [SRC_W-1:0]     head_src;
    logic [NUM_CORES-1:0] head_dest;

    // Scan requesters starting at rr_ptr, wrapping at NUM_CORES.
    always_comb begin : arbiter
        int idx;
        logic [SRC_W-1:0] cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        cand        = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_CORES) idx = idx - NUM_CORES;
            cand = SRC_W'(idx);
            if (!grant_found && write_req[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign full        = (occupancy == FULL_LEVEL);
    assign empty       = (occupancy == '0) && !bcast_valid;
    assign allow_write = !clear && (!full || (OVERWRITE != 0));
    assign grant_any   = grant_found && allow_write;

    always_comb begin
        write_grant = '0;
        if (grant_any) write_grant[grant_idx] = 1'b1;
    end

    assign {head_data, head_src} = mem[read_ptr];

    always_comb begin
        head_dest = '1;
        if (SKIP_SELF != 0) head_dest[head_src] = 1'b0;
    end

    assign transfer = bcast_valid && ((bcast_ready & bcast_dest) == bcast_dest);
    assign load     = !clear && (occupancy != '0) && (!bcast_valid || transfer);
    // When full, write_ptr equals read_ptr, so an overwrite lands on the discarded head slot.
    assign discard    = grant_any && full && !load;
    assign store_inc  = grant_any && !discard;
    assign drop_event = !clear && (((OVERWRITE == 0) && full && (|write_req)) || discard);

    always_ff @(posedge clk) begin
        if (grant_any) mem[write_ptr] <= {write_data[grant_idx], grant_idx};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_ptr   <= '0;
            read_ptr    <= '0;
            occupancy   <= '0;
            rr_ptr      <= '0;
            drop_count  <= '0;
            bcast_valid <= 1'b0;
            bcast_data  <= '0;
            bcast_src   <= '0;
            bcast_dest  <= '0;
        end else begin
            if (grant_any)
                rr_ptr <= (grant_idx == SRC_W'(NUM_CORES - 1)) ? '0 : grant_idx + 1'b1;
            if (drop_event && (drop_count != 16'hFFFF))
                drop_count <= drop_count + 1'b1;
            if (clear) begin
                write_ptr   <= '0;
                read_ptr    <= '0;
                occupancy   <= '0;
                bcast_valid <= 1'b0;
            end else begin
                if (grant_any) write_ptr <= write_ptr + 1'b1;
                if (load || discard) read_ptr <= read_ptr + 1'b1;
                if (store_inc && !load)
                    occupancy <= occupancy + 1'b1;
                else if (!store_inc && load)
                    occupancy <= occupancy - 1'b1;
                if (load) begin
                    bcast_valid <= 1'b1;
                    bcast_data  <= head_data;
                    bcast_src   <= head_src;
                    bcast_dest  <= head_dest;
                end else if (transfer) begin
                    bcast_valid <= 1'b0;
                end
            end
        end
    end

endmodule
